// File: rtl/rx_frame_splitter_if.sv
// Bundle of the RX byte stream, header/body FIFO write ports and drop counter
// for one rx_frame_splitter instance.
interface rx_frame_splitter_if #(
    parameter int HEADER_DWIDTH = 128
);
    logic                     rx_valid;
    logic [7:0]               rx_data;
    logic                     rx_sof;
    logic                     rx_eof;
    logic                     rx_fcs_ok;
    logic [HEADER_DWIDTH-1:0] h_fifo_din;
    logic                     h_fifo_wren;
    logic                     h_fifo_afull;
    logic [7:0]               b_fifo_din;
    logic                     b_fifo_del;
    logic                     b_fifo_wren;
    logic                     b_fifo_afull;
    logic [15:0]              drop_cnt;

    // Master: PHY deframer + FIFO side driving the splitter.
    modport master (
        output rx_valid, rx_data, rx_sof, rx_eof, rx_fcs_ok, h_fifo_afull, b_fifo_afull,
        input  h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_del, b_fifo_wren, drop_cnt
    );

    // Slave: the splitter itself.
    modport slave (
        input  rx_valid, rx_data, rx_sof, rx_eof, rx_fcs_ok, h_fifo_afull, b_fifo_afull,
        output h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_del, b_fifo_wren, drop_cnt
    );
endinterface

// File: rtl/rx_frame_splitter.sv
// Splits an RX byte stream into a 128-bit Ethernet II header word and a delimited body stream.
// Optional feature macro: RX_CTRL_DETECT_EN (flags 01-80-C2-00-00-0x destinations as control frames).
module rx_frame_splitter #(
    parameter int PORT_ID       = 0,
    parameter int HEADER_DWIDTH = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    rx_frame_splitter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DISCARD} state_t;

    localparam logic [1:0] PORT_BITS = 2'(PORT_ID);

    state_t                   state_q, state_d;
    logic [3:0]               idx_q, idx_d;
    logic                     commit_hdr_q, commit_hdr_d;
    logic [111:0]             hdr_q, hdr_d;
    logic [15:0]              drop_cnt_q, drop_cnt_d;
    logic [HEADER_DWIDTH-1:0] h_din_q, h_din_d;
    logic                     h_wren_q, h_wren_d;
    logic [7:0]               b_din_q, b_din_d;
    logic                     b_del_q, b_del_d;
    logic                     b_wren_q, b_wren_d;
    logic [1:0]               drop_inc;
    logic [16:0]              drop_sum;
    logic                     is_ctrl;
    logic                     afull_any;

`ifdef RX_CTRL_DETECT_EN
    assign is_ctrl = (hdr_q[111:68] == 44'h0180C200000);
`else
    assign is_ctrl = 1'b0;
`endif

    assign afull_any = bus.h_fifo_afull | bus.b_fifo_afull;
    assign drop_sum  = {1'b0, drop_cnt_q} + {15'd0, drop_inc};

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        commit_hdr_d = commit_hdr_q;
        hdr_d        = hdr_q;
        h_din_d      = h_din_q;
        h_wren_d     = 1'b0;
        b_din_d      = b_din_q;
        b_del_d      = 1'b0;
        b_wren_d     = 1'b0;
        drop_inc     = 2'd0;

        case (state_q)
            S_IDLE, S_HDR: begin
                if (bus.rx_valid && bus.rx_sof) begin
                    // A new SOF while still collecting a header abandons the partial frame.
                    if (state_q == S_HDR)
                        drop_inc = 2'd1;
                    hdr_d = {104'd0, bus.rx_data};
                    if (bus.rx_eof) begin
                        drop_inc = drop_inc + 2'd1;
                        state_d  = S_IDLE;
                    end else if (afull_any) begin
                        drop_inc     = drop_inc + 2'd1;
                        commit_hdr_d = 1'b0;
                        state_d      = S_DISCARD;
                    end else begin
                        idx_d   = 4'd1;
                        state_d = S_HDR;
                    end
                end else if (bus.rx_valid && state_q == S_HDR) begin
                    hdr_d = {hdr_q[103:0], bus.rx_data};
                    if (bus.rx_eof) begin
                        drop_inc = 2'd1;
                        state_d  = S_IDLE;
                    end else if (idx_q == 4'd13) begin
                        state_d = S_BODY;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            S_BODY: begin
                if (bus.rx_valid && bus.rx_sof) begin
                    // Close the interrupted frame with a pad delimiter; the newcomer is dropped.
                    b_wren_d     = 1'b1;
                    b_din_d      = 8'h00;
                    b_del_d      = 1'b1;
                    h_wren_d     = 1'b1;
                    h_din_d      = HEADER_DWIDTH'({1'b0, is_ctrl, PORT_BITS, hdr_q});
                    drop_inc     = 2'd2;
                    commit_hdr_d = 1'b0;
                    state_d      = bus.rx_eof ? S_IDLE : S_DISCARD;
                end else if (bus.rx_valid) begin
                    b_wren_d = 1'b1;
                    b_din_d  = bus.rx_data;
                    if (bus.rx_eof) begin
                        b_del_d  = 1'b1;
                        h_wren_d = 1'b1;
                        h_din_d  = HEADER_DWIDTH'({bus.rx_fcs_ok, is_ctrl, PORT_BITS, hdr_q});
                        state_d  = S_IDLE;
                    end else if (bus.b_fifo_afull) begin
                        b_del_d      = 1'b1;
                        commit_hdr_d = 1'b1;
                        drop_inc     = 2'd1;
                        state_d      = S_DISCARD;
                    end
                end
            end

            S_DISCARD: begin
                if (bus.rx_valid && (bus.rx_sof || bus.rx_eof)) begin
                    // A truncated frame still owes its header; it goes out at the first boundary.
                    if (commit_hdr_q) begin
                        h_wren_d = 1'b1;
                        h_din_d  = HEADER_DWIDTH'({1'b0, is_ctrl, PORT_BITS, hdr_q});
                    end
                    commit_hdr_d = 1'b0;
                    if (bus.rx_sof)
                        drop_inc = 2'd1;
                    state_d = bus.rx_eof ? S_IDLE : S_DISCARD;
                end
            end

            default: state_d = S_IDLE;
        endcase

        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 4'd0;
            commit_hdr_q <= 1'b0;
            hdr_q        <= '0;
            drop_cnt_q   <= 16'd0;
            h_din_q      <= '0;
            h_wren_q     <= 1'b0;
            b_din_q      <= 8'd0;
            b_del_q      <= 1'b0;
            b_wren_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            commit_hdr_q <= commit_hdr_d;
            hdr_q        <= hdr_d;
            drop_cnt_q   <= drop_cnt_d;
            h_din_q      <= h_din_d;
            h_wren_q     <= h_wren_d;
            b_din_q      <= b_din_d;
            b_del_q      <= b_del_d;
            b_wren_q     <= b_wren_d;
        end
    end

    assign bus.h_fifo_din  = h_din_q;
    assign bus.h_fifo_wren = h_wren_q;
    assign bus.b_fifo_din  = b_din_q;
    assign bus.b_fifo_del  = b_del_q;
    assign bus.b_fifo_wren = b_wren_q;
    assign bus.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_rx_frame_splitter.sv
// Bench for rx_frame_splitter: vector table of whole frames plus hand-built mid-frame corner
// cases; body bytes and header words are predicted into queues and popped as the DUT writes.
module tb_rx_frame_splitter;
    localparam int HW = 128;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rx_frame_splitter_if #(.HEADER_DWIDTH(HW)) bus ();

    rx_frame_splitter #(.PORT_ID(2), .HEADER_DWIDTH(HW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          len;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        bit          fcs;
        int          afull_at;
        int          exp_nbody;
        int          exp_nhdr;
        int          exp_drops;
    } vec_t;

    vec_t            vecs[7];
    logic [8:0]      body_exp_q[$];
    logic [HW-1:0]   hdr_exp_q[$];
    int              checks = 0;
    int              failures = 0;
    int              body_seen = 0;
    int              hdr_seen = 0;
    int              exp_drop = 0;
    logic [HW-1:0]   last_hdr = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int i, input int len, input logic [47:0] dst,
                                         input logic [47:0] src, input logic [15:0] et);
        if (i < 6)       return dst[8*(5-i) +: 8];
        else if (i < 12) return src[8*(11-i) +: 8];
        else if (i < 14) return et[8*(13-i) +: 8];
        else             return 8'(i * 7 + len);
    endfunction

    function automatic logic [HW-1:0] mk_hdr(input bit fv, input logic [47:0] dst,
                                             input logic [47:0] src, input logic [15:0] et);
        logic ctrl;
`ifdef RX_CTRL_DETECT_EN
        ctrl = (dst[47:4] == 44'h0180C200000);
`else
        ctrl = 1'b0;
`endif
        return {12'd0, fv, ctrl, 2'd2, dst, src, et};
    endfunction

    // Scoreboard side: every DUT write must match the head of its queue.
    always @(negedge clk) begin
        if (bus.b_fifo_wren) begin
            body_seen++;
            if (body_exp_q.size() == 0) chk("body_unexpected", 128'({bus.b_fifo_del, bus.b_fifo_din}), 128'h1_FFFF);
            else chk("body_byte", 128'({bus.b_fifo_del, bus.b_fifo_din}), 128'(body_exp_q.pop_front()));
        end
        if (bus.h_fifo_wren) begin
            hdr_seen++;
            last_hdr = bus.h_fifo_din;
            if (hdr_exp_q.size() == 0) chk("hdr_unexpected", bus.h_fifo_din, {128{1'b1}});
            else chk("hdr_word", bus.h_fifo_din, hdr_exp_q.pop_front());
        end
    end

    task automatic drive(input logic [7:0] d, input bit sof, input bit eof, input bit fcs, input bit bafull);
        bus.rx_valid     = 1'b1;
        bus.rx_data      = d;
        bus.rx_sof       = sof;
        bus.rx_eof       = eof;
        bus.rx_fcs_ok    = fcs;
        bus.b_fifo_afull = bafull;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_sof   = 1'b0;
        bus.rx_eof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // stop_at >= 0: drive only that many bytes (no eof); dropped: push no expectations.
    task automatic send_frame(input int len, input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] et, input bit fcs, input int afull_at,
                              input int stop_at, input bit dropped);
        int  n_drv   = (stop_at >= 0) ? stop_at : len;
        int  nb_drv  = n_drv - 14;
        bit  has_eof = (stop_at < 0);
        bit  trunc   = (afull_at >= 0) && (afull_at < nb_drv) && !(has_eof && afull_at == nb_drv - 1);
        int  n_push  = trunc ? afull_at + 1 : nb_drv;
        if (!dropped && nb_drv > 0) begin
            for (int j = 0; j < n_push; j++) begin
                bit del = trunc ? (j == afull_at) : (has_eof && j == nb_drv - 1);
                body_exp_q.push_back({del, fbyte(14 + j, len, dst, src, et)});
            end
            if (has_eof) hdr_exp_q.push_back(mk_hdr(trunc ? 1'b0 : fcs, dst, src, et));
        end
        for (int i = 0; i < n_drv; i++)
            drive(fbyte(i, len, dst, src, et), i == 0, has_eof && i == len - 1, fcs,
                  afull_at >= 0 && i - 14 >= afull_at);
        bus.b_fifo_afull = 1'b0;
    endtask

    task automatic check_counts(input string name, input int b0, input int h0, input int nb, input int nh);
        chk({name, "_nbody"}, 128'(body_seen - b0), 128'(nb));
        chk({name, "_nhdr"}, 128'(hdr_seen - h0), 128'(nh));
        chk({name, "_drop_cnt"}, 128'(bus.drop_cnt), 128'(exp_drop));
    endtask

    initial begin
        int b0, h0;
        rst_n            = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = 8'd0;
        bus.rx_sof       = 1'b0;
        bus.rx_eof       = 1'b0;
        bus.rx_fcs_ok    = 1'b0;
        bus.h_fifo_afull = 1'b0;
        bus.b_fifo_afull = 1'b0;
        idle(3);
        chk("rst_h_din", bus.h_fifo_din, 128'd0);
        chk("rst_h_wren", 128'(bus.h_fifo_wren), 128'd0);
        chk("rst_b_din", 128'(bus.b_fifo_din), 128'd0);
        chk("rst_b_del", 128'(bus.b_fifo_del), 128'd0);
        chk("rst_b_wren", 128'(bus.b_fifo_wren), 128'd0);
        chk("rst_drop_cnt", 128'(bus.drop_cnt), 128'd0);
        rst_n = 1'b1;
        idle(1);

        vecs[0] = '{64, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800, 1'b1, -1, 50, 1, 0};
        vecs[1] = '{64, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800, 1'b0, -1, 50, 1, 0};
        vecs[2] = '{10, 48'h001122334455, 48'h020000000002, 16'h0800, 1'b1, -1, 0, 0, 1};
        vecs[3] = '{100, 48'h00AABBCCDDEE, 48'h020000000003, 16'h86DD, 1'b1, 19, 20, 1, 1};
        vecs[4] = '{60, 48'h0180C2000001, 48'h020000000004, 16'h8808, 1'b1, -1, 46, 1, 0};
        vecs[5] = '{15, 48'h0A0B0C0D0E0F, 48'h020000000005, 16'h0806, 1'b1, -1, 1, 1, 0};
        vecs[6] = '{14, 48'h0A0B0C0D0E0F, 48'h020000000006, 16'h0806, 1'b1, -1, 0, 0, 1};

        for (int v = 0; v < 7; v++) begin
            b0 = body_seen;
            h0 = hdr_seen;
            send_frame(vecs[v].len, vecs[v].dst, vecs[v].src, vecs[v].et, vecs[v].fcs,
                       vecs[v].afull_at, -1, 1'b0);
            idle(4);
            exp_drop += vecs[v].exp_drops;
            check_counts($sformatf("vec%0d", v), b0, h0, vecs[v].exp_nbody, vecs[v].exp_nhdr);
            $display("vector %0d: len=%0d body=%0d hdr=%0d drop_cnt=%0d", v, vecs[v].len,
                     body_seen - b0, hdr_seen - h0, bus.drop_cnt);
            if (v == 0) chk("vec0_hdr_literal", last_hdr, 128'h000A_FFFF_FFFF_FFFF_0200_0000_0001_0800);
        end

        // Header FIFO almost full at SOF: whole frame dropped, next one normal.
        b0 = body_seen; h0 = hdr_seen;
        bus.h_fifo_afull = 1'b1;
        send_frame(40, 48'h111111111111, 48'h020000000010, 16'h0800, 1'b1, -1, -1, 1'b1);
        bus.h_fifo_afull = 1'b0;
        idle(3);
        exp_drop += 1;
        check_counts("hafull_drop", b0, h0, 0, 0);
        b0 = body_seen; h0 = hdr_seen;
        send_frame(30, 48'h111111111112, 48'h020000000011, 16'h0800, 1'b1, -1, -1, 1'b0);
        idle(3);
        check_counts("hafull_recover", b0, h0, 16, 1);
        $display("seq hafull: drop_cnt=%0d", bus.drop_cnt);

        // SOF in the body: pad delimiter + invalid header, newcomer dropped (+2).
        b0 = body_seen; h0 = hdr_seen;
        send_frame(30, 48'h222222222222, 48'h020000000020, 16'h0800, 1'b1, -1, 20, 1'b0);
        body_exp_q.push_back({1'b1, 8'h00});
        hdr_exp_q.push_back(mk_hdr(1'b0, 48'h222222222222, 48'h020000000020, 16'h0800));
        send_frame(30, 48'h333333333333, 48'h020000000021, 16'h0800, 1'b1, -1, -1, 1'b1);
        idle(3);
        exp_drop += 2;
        check_counts("sof_in_body", b0, h0, 7, 1);
        $display("seq sof_in_body: drop_cnt=%0d", bus.drop_cnt);

        // SOF in the header: partial abandoned (+1), new frame processed normally.
        b0 = body_seen; h0 = hdr_seen;
        send_frame(64, 48'h444444444444, 48'h020000000030, 16'h0800, 1'b1, -1, 8, 1'b0);
        send_frame(64, 48'h555555555555, 48'h020000000031, 16'h0800, 1'b1, -1, -1, 1'b0);
        idle(3);
        exp_drop += 1;
        check_counts("sof_in_hdr", b0, h0, 50, 1);
        $display("seq sof_in_hdr: drop_cnt=%0d", bus.drop_cnt);

        // Truncation then SOF while discarding: pending header flushed, newcomer dropped.
        b0 = body_seen; h0 = hdr_seen;
        send_frame(100, 48'h666666666666, 48'h020000000040, 16'h0800, 1'b1, 5, 40, 1'b0);
        hdr_exp_q.push_back(mk_hdr(1'b0, 48'h666666666666, 48'h020000000040, 16'h0800));
        send_frame(30, 48'h777777777777, 48'h020000000041, 16'h0800, 1'b1, -1, -1, 1'b1);
        idle(3);
        exp_drop += 2;
        check_counts("sof_in_discard", b0, h0, 6, 1);
        $display("seq sof_in_discard: drop_cnt=%0d", bus.drop_cnt);

        // Back-to-back frames with no idle cycle between eof and sof.
        b0 = body_seen; h0 = hdr_seen;
        send_frame(20, 48'h888888888888, 48'h020000000050, 16'h0800, 1'b1, -1, -1, 1'b0);
        send_frame(20, 48'h999999999999, 48'h020000000051, 16'h0800, 1'b0, -1, -1, 1'b0);
        idle(3);
        check_counts("back_to_back", b0, h0, 12, 2);
        $display("seq back_to_back: body=%0d hdr=%0d", body_seen - b0, hdr_seen - h0);

        // Reset mid-frame: no further writes, counter cleared, next frame normal.
        b0 = body_seen; h0 = hdr_seen;
        send_frame(30, 48'hAAAAAAAAAAAA, 48'h020000000060, 16'h0800, 1'b1, -1, 20, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        exp_drop = 0;
        idle(3);
        check_counts("reset_mid", b0, h0, 6, 0);
        b0 = body_seen; h0 = hdr_seen;
        send_frame(20, 48'hBBBBBBBBBBBB, 48'h020000000061, 16'h0800, 1'b1, -1, -1, 1'b0);
        idle(3);
        check_counts("after_reset", b0, h0, 6, 1);
        $display("seq reset_mid: drop_cnt=%0d", bus.drop_cnt);

        chk("body_queue_empty", 128'(body_exp_q.size()), 128'd0);
        chk("hdr_queue_empty", 128'(hdr_exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
